// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load funct3 encodings, writeback
// error codes, writeback FSM states and small decode helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_WRITE    = 2'b10
  } wb_state_t;

  // Opcodes whose result comes straight from the ALU/jump path.
  function automatic logic is_alu_writeback(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // funct3 values that do not name a load width on RV32.
  function automatic logic is_illegal_load(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && off[0]) ||
           ((f3 == F3_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half from a word-aligned bus word and
// sign- or zero-extends it according to the load funct3.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = 8'(mem_rdata >> {byte_off, 3'b000});
  assign half_val = 16'(mem_rdata >> {byte_off[1], 4'b0000});

  // Width/sign selection; anything that is not a sub-word load passes the word through.
  always_comb begin
    ext_data = mem_rdata;
    case (funct3)
      F3_LB:   ext_data = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH:   ext_data = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_val};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage after memory access. ALU/jump results are written one
// cycle after issue; loads wait for the data bus, are aligned/extended and
// written in the WRITE cycle. Misaligned, illegal and timed-out loads
// retire with an error pulse and no register write.
//
// Handshake: en is an issue strobe accepted only while busy=0; an en seen
// while busy=1 is dropped, so upstream must hold off while busy is high.
// mem_rvalid is a one-cycle response strobe honoured only in WAIT_MEM.
module load_writeback
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire,
  output logic            err,
  output logic [1:0]      err_code
);

  wb_state_t       state;
  logic [7:0]      wait_cnt;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic [XLEN-1:0] ext_data;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3    (ld_f3),
    .byte_off  (ld_off),
    .mem_rdata (mem_rdata),
    .ext_data  (ext_data)
  );

  // Busy covers the whole load window, including the WRITE cycle.
  assign busy = (state != ST_IDLE);

  // FSM, captured load context, timeout counter and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_off   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            if (opcode == OPC_LOAD) begin
              if (is_illegal_load(funct3)) begin
                retire   <= 1'b1;
                err      <= 1'b1;
                err_code <= ERR_ILLEGAL;
              end else if (is_misaligned(funct3, byte_off)) begin
                retire   <= 1'b1;
                err      <= 1'b1;
                err_code <= ERR_MISALIGN;
              end else begin
                ld_rd    <= rd;
                ld_f3    <= funct3;
                ld_off   <= byte_off;
                wait_cnt <= '0;
                state    <= ST_WAIT_MEM;
              end
            end else if (is_alu_writeback(opcode)) begin
              rf_we    <= (rd != 5'd0);
              rf_waddr <= rd;
              rf_wdata <= alu_result;
              retire   <= 1'b1;
            end else begin
              retire <= 1'b1;
            end
          end
        end
        ST_WAIT_MEM: begin
          // A response in the final counted cycle still beats the timeout.
          if (mem_rvalid) begin
            rf_we    <= (ld_rd != 5'd0);
            rf_waddr <= ld_rd;
            rf_wdata <= ext_data;
            retire   <= 1'b1;
            state    <= ST_WRITE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            retire   <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Directed + lightly randomised bench for load_writeback with a
// retire-ordered scoreboard.
module tb_load_writeback;
  import riscv_pkg::*;

  localparam int W = 41; // {we, waddr[4:0], wdata[31:0], err, code[1:0]}

  logic        clk;
  logic        reset;
  logic        en;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  byte_off;
  logic [31:0] alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  load_writeback #(.TIMEOUT(16), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd         (rd),
    .byte_off   (byte_off),
    .alu_result (alu_result),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .retire     (retire),
    .err        (err),
    .err_code   (err_code)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic e, input logic [1:0] code);
    exp_q.push_back({we, wa, wd, e, code});
  endtask

  task automatic drive_issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] r,
                             input logic [1:0] off, input logic [31:0] alu);
    en         = 1'b1;
    opcode     = opc;
    funct3     = f3;
    rd         = r;
    byte_off   = off;
    alu_result = alu;
  endtask

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Full legal load: issue, wait_n idle WAIT_MEM cycles, respond, check WRITE cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] r,
                         input logic [1:0] off, input logic [31:0] word, input int wait_n);
    logic [31:0] e;
    e = model_ext(f3, off, word);
    drive_issue(OPC_LOAD, f3, r, off, 32'h0);
    step();
    en = 1'b0;
    chk({tag, "_busy_wait"}, busy, 1);
    repeat (wait_n) begin
      step();
      chk({tag, "_no_early_we"}, rf_we, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    push_exp(r != 0, r, e, 1'b0, 2'b00);
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_write_busy"}, busy, 1);
    chk({tag, "_write_we"}, rf_we, (r != 0));
    chk({tag, "_write_retire"}, retire, 1);
    if (r != 0) chk({tag, "_write_data"}, rf_wdata, e);
    step();
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_we_clear"}, rf_we, 0);
  endtask

  // Scoreboard: every retire pulse pops one expectation, in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (retire) begin
        chk("sb_retire_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_we", rf_we, mon_e[40]);
          chk("sb_err", err, mon_e[2]);
          if (mon_e[2]) chk("sb_err_code", err_code, mon_e[1:0]);
          if (mon_e[40]) begin
            chk("sb_waddr", rf_waddr, mon_e[39:35]);
            chk("sb_wdata", rf_wdata, mon_e[34:3]);
          end
        end
      end else if (rf_we || err) begin
        chk("sb_pulse_without_retire", {rf_we, err}, 0);
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; opcode = '0; funct3 = '0; rd = '0; byte_off = '0;
    alu_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    // Reset state
    chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    chk("rst_busy", busy, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_err", err, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_code", err_code, 0);
    reset = 1'b0;
    step();

    // Sign/zero extension cases
    do_load("lb_off3", F3_LB, 5'd5, 2'd3, 32'h80123456, 2);
    do_load("lhu_off2", F3_LHU, 5'd6, 2'd2, 32'hBEEF1234, 1);
    do_load("lh_off2", F3_LH, 5'd6, 2'd2, 32'hBEEF1234, 0);
    do_load("lbu_off1", F3_LBU, 5'd8, 2'd1, 32'h80123456, 3);
    do_load("lw_off0", F3_LW, 5'd9, 2'd0, 32'hCAFEF00D, 1);
    do_load("lb_rd0", F3_LB, 5'd0, 2'd0, 32'h000000FF, 1);

    // Response in the issue cycle must be ignored
    drive_issue(OPC_LOAD, F3_LBU, 5'd10, 2'd0, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAAAAAA;
    step();
    en = 1'b0; mem_rvalid = 1'b0;
    chk("issue_rvalid_ignored_busy", busy, 1);
    chk("issue_rvalid_ignored_we", rf_we, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
    push_exp(1'b1, 5'd10, 32'h00000055, 1'b0, 2'b00);
    step();
    mem_rvalid = 1'b0;
    chk("earliest_rvalid_we", rf_we, 1);
    chk("earliest_rvalid_data", rf_wdata, 32'h00000055);
    step();

    // Misaligned and illegal loads: one-cycle error, never busy
    drive_issue(OPC_LOAD, F3_LW, 5'd3, 2'd2, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b1, 2'b01);
    step();
    en = 1'b0;
    chk("misalign_lw_busy", busy, 0);
    chk("misalign_lw_err", err, 1);
    chk("misalign_lw_code", err_code, 2'b01);
    chk("misalign_lw_we", rf_we, 0);
    drive_issue(OPC_LOAD, F3_LH, 5'd3, 2'd1, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b1, 2'b01);
    step();
    en = 1'b0;
    chk("misalign_lh_code", err_code, 2'b01);
    chk("misalign_lh_busy", busy, 0);
    drive_issue(OPC_LOAD, 3'b111, 5'd3, 2'd0, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b1, 2'b10);
    step();
    en = 1'b0;
    chk("illegal_f3_111_code", err_code, 2'b10);
    chk("illegal_f3_111_busy", busy, 0);
    drive_issue(OPC_LOAD, 3'b011, 5'd3, 2'd0, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b1, 2'b10);
    step();
    en = 1'b0;
    chk("illegal_f3_011_code", err_code, 2'b10);
    step();

    // Timeout: error exactly 16 cycles after entering WAIT_MEM
    drive_issue(OPC_LOAD, F3_LW, 5'd9, 2'd0, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b1, 2'b11);
    step();
    en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("timeout_not_early", err, 0);
      chk("timeout_busy", busy, 1);
    end
    step();
    chk("timeout_err", err, 1);
    chk("timeout_code", err_code, 2'b11);
    chk("timeout_retire", retire, 1);
    chk("timeout_we", rf_we, 0);
    chk("timeout_idle", 64'(dut.state), 64'(ST_IDLE));
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 1'b0;
    chk("late_rvalid_we", rf_we, 0);
    chk("late_rvalid_retire", retire, 0);
    chk("late_rvalid_busy", busy, 0);

    // Back-to-back ALU ops, rd=7 then rd=0
    drive_issue(OPC_OP, 3'b000, 5'd7, 2'd0, 32'h00000011);
    push_exp(1'b1, 5'd7, 32'h00000011, 1'b0, 2'b00);
    step();
    drive_issue(OPC_OP, 3'b000, 5'd0, 2'd0, 32'h00000022);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 2'b00);
    chk("b2b_first_we", rf_we, 1);
    chk("b2b_first_addr", rf_waddr, 5'd7);
    chk("b2b_first_retire", retire, 1);
    step();
    en = 1'b0;
    chk("b2b_second_we", rf_we, 0);
    chk("b2b_second_retire", retire, 1);
    chk("b2b_second_wdata", rf_wdata, 32'h00000022);

    // Other writeback opcodes and non-writing opcodes
    drive_issue(OPC_LUI, 3'b000, 5'd31, 2'd0, 32'hABCDE000);
    push_exp(1'b1, 5'd31, 32'hABCDE000, 1'b0, 2'b00);
    step();
    drive_issue(OPC_JAL, 3'b000, 5'd1, 2'd0, 32'h00001004);
    push_exp(1'b1, 5'd1, 32'h00001004, 1'b0, 2'b00);
    step();
    drive_issue(7'b0100011, 3'b010, 5'd4, 2'd0, 32'hDEADBEEF);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 2'b00);
    step();
    drive_issue(7'b1110011, 3'b000, 5'd4, 2'd0, 32'hDEADBEEF);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 2'b00);
    step();
    en = 1'b0;
    chk("system_no_we", rf_we, 0);
    chk("system_retire", retire, 1);
    step();

    // en during WAIT_MEM and WRITE is dropped
    drive_issue(OPC_LOAD, F3_LW, 5'd3, 2'd0, 32'h0);
    step();
    drive_issue(OPC_OP, 3'b000, 5'd4, 2'd0, 32'h0BAD0BAD);
    step();
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h01020304;
    push_exp(1'b1, 5'd3, 32'h01020304, 1'b0, 2'b00);
    step();
    mem_rvalid = 1'b0;
    chk("drop_en_load_addr", rf_waddr, 5'd3);
    step();
    en = 1'b0;
    chk("drop_en_no_alu_we", rf_we, 0);
    chk("drop_en_no_retire", retire, 0);
    step();
    chk("drop_en_idle_quiet", retire, 0);

    // Randomised legal loads
    for (int k = 0; k < 6; k++) begin
      logic [2:0] f3;
      logic [1:0] off;
      case ($urandom_range(0, 4))
        0: f3 = F3_LB;
        1: f3 = F3_LBU;
        2: f3 = F3_LH;
        3: f3 = F3_LHU;
        default: f3 = F3_LW;
      endcase
      if (f3 == F3_LW) off = 2'd0;
      else if (f3 == F3_LH || f3 == F3_LHU) off = {1'($urandom_range(0, 1)), 1'b0};
      else off = 2'($urandom_range(0, 3));
      do_load("rand_load", f3, 5'($urandom_range(0, 31)), off, $urandom, $urandom_range(0, 5));
    end

    // Reset during WAIT_MEM, response arrives the cycle after
    drive_issue(OPC_LOAD, F3_LW, 5'd6, 2'd0, 32'h0);
    step();
    en = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    chk("midrst_state", 64'(dut.state), 64'(ST_IDLE));
    chk("midrst_busy", busy, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_waddr", rf_waddr, 0);
    chk("midrst_wdata", rf_wdata, 0);
    chk("midrst_code", err_code, 0);
    step();
    mem_rvalid = 1'b0;
    chk("midrst_late_we", rf_we, 0);
    chk("midrst_late_retire", retire, 0);
    chk("midrst_late_busy", busy, 0);
    step();
    step();

    chk("sb_queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
